kernel_window_fetch: RTL and testbench
======================================

Name: kernel_window_fetch

Overview:
- Parametrised successor to the fixed 3x3 neighbourhood fetcher.
- Gathers a KxK pixel window around a requested centre pixel from single-port image memory with configurable read latency.
- Presents the window as one flattened bus with a start/valid handshake.
- Sits between the pixel-iteration controller and the convolution/filter datapath.

Parameters:
IMG_W, 256, image width in pixels (>=K)
IMG_H, 256, image height in pixels (>=K)
K, 3, kernel edge size; odd, 3..7
DW, 17, pixel data width
AW, 16, memory address width; must satisfy 2^AW >= IMG_W*IMG_H
RD_LAT, 1, memory read latency in cycles (1..4)

Ports:
clk  in  1  clock, rising edge
n_rst  in  1  asynchronous active-low reset
start  in  1  request pulse; sampled only when busy=0
center_row  in  AW  centre pixel row
center_col  in  AW  centre pixel column
busy  out  1  high from accepted start until valid pulse
err  out  1  one-cycle pulse: start rejected, centre out of range
mem_addr  out  AW  memory read address, registered
mem_rd  out  1  read strobe, registered
mem_data  in  DW  memory read data, valid RD_LAT cycles after mem_rd sampled
window  out  K*K*DW  taps; tap t at bits [t*DW +: DW], t = dy_idx*K + dx_idx, raster order, tap 0 top-left
valid  out  1  one-cycle pulse: window complete

Behaviour:
- Reset (async, n_rst=0):
  - busy, err, valid, mem_rd, mem_addr, window all 0.
  - FSM to IDLE.
  - Read-tracking pipeline cleared.
  - Reset mid-operation aborts the fetch; data returning afterwards is ignored.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE:
    - If start=1 and center_row<IMG_H and center_col<IMG_W: latch the centre, tap counter=0, busy=1, go to ISSUE.
    - If start=1 and the centre is out of range: err pulses for one cycle, stay in IDLE.
  - ISSUE:
    - One read per cycle: mem_rd=1, mem_addr = r*IMG_W + c for the current tap.
    - After tap K*K-1 is issued, go to DRAIN.
  - DRAIN:
    - mem_rd=0; wait for the outstanding reads to return.
    - When the last tap is captured: valid=1 for one cycle, busy=0, return to IDLE.
- Neighbour coordinates:
  - r = center_row + dy, c = center_col + dx, with dy,dx in [-(K-1)/2, +(K-1)/2].
  - Computed signed, one bit wider than AW.
  - Clamped to [0,IMG_H-1] and [0,IMG_W-1] independently (edge replication).
- Capture:
  - The tap index travels a RD_LAT-deep shift register alongside mem_rd.
  - mem_data is written into the matching tap slot on the edge where the delayed strobe is high.
- Timing:
  - start accepted at edge E0; mem_rd high for cycles E1..E(K*K).
  - Final tap captured and valid asserted at edge E(K*K+RD_LAT).
  - Default configuration: valid 10 cycles after start.
- window holds its previous contents until overwritten tap by tap during the next fetch. Only the valid cycle guarantees consistency.
- start while busy=1 is ignored: no err, no effect on the current fetch.
- start in the same cycle valid pulses is ignored; busy is still 1 that cycle. The earliest new start is the following cycle.
- Back-to-back fetches have no wasted cycles beyond the single IDLE cycle.

Optional Feature:
- Macro: KWIN_ZERO_PAD_EN.
- Defined:
  - Taps whose unclamped r or c fall outside the image capture 0 instead of memory data.
  - The out-of-range flag rides the capture pipeline with the tap index.
  - Read cycles and timing are unchanged: the clamped address is still issued.
- Undefined: edge replication only, no flag pipeline logic.

Test Plan:
- Interior, K=3, RD_LAT=1, IMG_W=IMG_H=256, memory[a]=a: start row=5 col=7 -> mem_addr sequence 1030,1031,1032,1286,1287,1288,1542,1543,1544; valid at E10; window taps equal those values.
- Corner clamp: row=0 col=0 -> taps {0,0,1,0,0,1,256,256,257}. Bottom-right row=255 col=255 -> tap 8 = 65535, tap 0 = 65278.
- Latency/K sweep: K=5, RD_LAT=3, row=10 col=10 -> 25 mem_rd cycles, valid exactly at E28, busy high E0..E27.
- Handshake: start held high through a fetch -> only one fetch, a second accepted the cycle after valid. row=256 -> err pulse, busy stays 0, no mem_rd.
- Reset mid-fetch: n_rst low during ISSUE tap 4 -> all outputs 0 immediately. Fresh start after release -> correct full window, no stale taps captured.
- With KWIN_ZERO_PAD_EN, row=0 col=0, K=3 -> taps {0,0,0,0,0,1,0,256,257}; timing identical to the non-padded run.

Source files
------------

// File: rtl/kernel_window_fetch.sv
// KxK neighbourhood fetcher: reads a clamped window around a centre pixel from
// single-port memory with RD_LAT read latency. Optional zero padding: KWIN_ZERO_PAD_EN.
module kernel_window_fetch #(
   parameter int unsigned IMG_W  = 256,
   parameter int unsigned IMG_H  = 256,
   parameter int unsigned K      = 3,
   parameter int unsigned DW     = 17,
   parameter int unsigned AW     = 16,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              start,
   input  logic [AW-1:0]     center_row,
   input  logic [AW-1:0]     center_col,
   output logic              busy,
   output logic              err,
   output logic [AW-1:0]     mem_addr,
   output logic              mem_rd,
   input  logic [DW-1:0]     mem_data,
   output logic [K*K*DW-1:0] window,
   output logic              valid
);

   localparam int unsigned KK   = K * K;
   localparam int unsigned TW   = $clog2(KK);
   localparam int unsigned IW   = $clog2(K);
   localparam int unsigned SW   = AW + 1;
   localparam int unsigned HALF = (K - 1) / 2;

   localparam logic signed [SW-1:0] HALF_S    = SW'(HALF);
   localparam logic signed [SW-1:0] ROW_MAX_S = SW'(IMG_H - 1);
   localparam logic signed [SW-1:0] COL_MAX_S = SW'(IMG_W - 1);
   localparam logic [AW-1:0]        ROW_MAX   = AW'(IMG_H - 1);
   localparam logic [AW-1:0]        COL_MAX   = AW'(IMG_W - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]               state_q, state_d;
   logic                     busy_q, busy_d;
   logic                     err_q, err_d;
   logic                     valid_q, valid_d;
   logic                     mem_rd_q, mem_rd_d;
   logic [AW-1:0]            mem_addr_q, mem_addr_d;
   logic [KK*DW-1:0]         window_q, window_d;
   logic [AW-1:0]            ctr_row_q, ctr_row_d;
   logic [AW-1:0]            ctr_col_q, ctr_col_d;
   logic [TW-1:0]            tap_q, tap_d;
   logic [IW-1:0]            dy_q, dy_d;
   logic [IW-1:0]            dx_q, dx_d;
   logic [RD_LAT-1:0]        rdv_q, rdv_d;
   logic [RD_LAT-1:0][TW-1:0] rtap_q, rtap_d;
`ifdef KWIN_ZERO_PAD_EN
   logic [RD_LAT-1:0]        rpad_q, rpad_d;
   logic                     pad_c;
`endif

   logic signed [SW-1:0] r_s_c, c_s_c;
   logic                 r_lo_c, r_hi_c, c_lo_c, c_hi_c;
   logic [AW-1:0]        r_cl_c, c_cl_c;
   logic [AW-1:0]        addr_c;
   logic                 start_ok_c;
   logic                 cap_c;
   logic [TW-1:0]        cap_tap_c;
   logic [DW-1:0]        cap_data_c;

   // Neighbour coordinate of the current tap, clamped to the image (edge replication).
   always_comb begin
      r_s_c  = $signed({1'b0, ctr_row_q}) + $signed(SW'(dy_q)) - HALF_S;
      c_s_c  = $signed({1'b0, ctr_col_q}) + $signed(SW'(dx_q)) - HALF_S;
      r_lo_c = r_s_c[SW-1];
      c_lo_c = c_s_c[SW-1];
      r_hi_c = (r_s_c > ROW_MAX_S);
      c_hi_c = (c_s_c > COL_MAX_S);
      if (r_lo_c)      r_cl_c = '0;
      else if (r_hi_c) r_cl_c = ROW_MAX;
      else             r_cl_c = AW'(r_s_c);
      if (c_lo_c)      c_cl_c = '0;
      else if (c_hi_c) c_cl_c = COL_MAX;
      else             c_cl_c = AW'(c_s_c);
      addr_c = AW'((2*AW)'(r_cl_c) * (2*AW)'(IMG_W) + (2*AW)'(c_cl_c));
   end

`ifdef KWIN_ZERO_PAD_EN
   assign pad_c = r_lo_c | r_hi_c | c_lo_c | c_hi_c;
`endif

   assign start_ok_c = ({1'b0, center_row} < SW'(IMG_H)) &&
                       ({1'b0, center_col} < SW'(IMG_W));

   assign cap_c     = rdv_q[RD_LAT-1];
   assign cap_tap_c = rtap_q[RD_LAT-1];
`ifdef KWIN_ZERO_PAD_EN
   assign cap_data_c = rpad_q[RD_LAT-1] ? '0 : mem_data;
`else
   assign cap_data_c = mem_data;
`endif

   // Next-state, read issue, return tracking and capture.
   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      err_d      = 1'b0;
      valid_d    = 1'b0;
      mem_rd_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      window_d   = window_q;
      ctr_row_d  = ctr_row_q;
      ctr_col_d  = ctr_col_q;
      tap_d      = tap_q;
      dy_d       = dy_q;
      dx_d       = dx_q;
      rdv_d      = '0;
      rtap_d     = '0;
`ifdef KWIN_ZERO_PAD_EN
      rpad_d     = '0;
`endif

      for (int unsigned i = 1; i < RD_LAT; i++) begin
         rdv_d[i]  = rdv_q[i-1];
         rtap_d[i] = rtap_q[i-1];
`ifdef KWIN_ZERO_PAD_EN
         rpad_d[i] = rpad_q[i-1];
`endif
      end

      for (int unsigned t = 0; t < KK; t++) begin
         if (cap_c && (cap_tap_c == TW'(t))) begin
            window_d[t*DW +: DW] = cap_data_c;
         end
      end

      case (state_q)
         S_IDLE: begin
            // busy is still high during the valid cycle, so a start there is ignored
            busy_d = 1'b0;
            if (start && !busy_q) begin
               if (start_ok_c) begin
                  ctr_row_d = center_row;
                  ctr_col_d = center_col;
                  tap_d     = '0;
                  dy_d      = '0;
                  dx_d      = '0;
                  busy_d    = 1'b1;
                  state_d   = S_ISSUE;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         S_ISSUE: begin
            mem_rd_d   = 1'b1;
            mem_addr_d = addr_c;
            rdv_d[0]   = 1'b1;
            rtap_d[0]  = tap_q;
`ifdef KWIN_ZERO_PAD_EN
            rpad_d[0]  = pad_c;
`endif
            if (tap_q == TW'(KK - 1)) begin
               state_d = S_DRAIN;
            end else begin
               tap_d = tap_q + TW'(1);
               if (dx_q == IW'(K - 1)) begin
                  dx_d = '0;
                  dy_d = dy_q + IW'(1);
               end else begin
                  dx_d = dx_q + IW'(1);
               end
            end
         end

         S_DRAIN: begin
            if (cap_c && (cap_tap_c == TW'(KK - 1))) begin
               valid_d = 1'b1;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= S_IDLE;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         valid_q    <= 1'b0;
         mem_rd_q   <= 1'b0;
         mem_addr_q <= '0;
         window_q   <= '0;
         ctr_row_q  <= '0;
         ctr_col_q  <= '0;
         tap_q      <= '0;
         dy_q       <= '0;
         dx_q       <= '0;
         rdv_q      <= '0;
         rtap_q     <= '0;
`ifdef KWIN_ZERO_PAD_EN
         rpad_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
         valid_q    <= valid_d;
         mem_rd_q   <= mem_rd_d;
         mem_addr_q <= mem_addr_d;
         window_q   <= window_d;
         ctr_row_q  <= ctr_row_d;
         ctr_col_q  <= ctr_col_d;
         tap_q      <= tap_d;
         dy_q       <= dy_d;
         dx_q       <= dx_d;
         rdv_q      <= rdv_d;
         rtap_q     <= rtap_d;
`ifdef KWIN_ZERO_PAD_EN
         rpad_q     <= rpad_d;
`endif
      end
   end

   assign busy     = busy_q;
   assign err      = err_q;
   assign valid    = valid_q;
   assign mem_rd   = mem_rd_q;
   assign mem_addr = mem_addr_q;
   assign window   = window_q;

endmodule

// File: tb/tb_kernel_window_fetch.sv
// Randomised bench for kernel_window_fetch against a coordinate-level window model
// and a latency-modelled memory; honours KWIN_ZERO_PAD_EN.
module tb_kernel_window_fetch;

   localparam int unsigned IMG_W  = 256;
   localparam int unsigned IMG_H  = 256;
   localparam int unsigned K      = 3;
   localparam int unsigned DW     = 17;
   localparam int unsigned AW     = 16;
   localparam int unsigned RD_LAT = 1;
   localparam int          KK     = K * K;
   localparam int          HALF   = (K - 1) / 2;

   logic              clk = 1'b0;
   logic              n_rst;
   logic              start;
   logic [AW-1:0]     center_row;
   logic [AW-1:0]     center_col;
   logic              busy;
   logic              err;
   logic [AW-1:0]     mem_addr;
   logic              mem_rd;
   logic [DW-1:0]     mem_data;
   logic [K*K*DW-1:0] window;
   logic              valid;

   int            n_vec = 0;
   int            n_err = 0;
   logic [DW-1:0] salt;

   always #5 clk = ~clk;

   kernel_window_fetch #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .DW(DW), .AW(AW), .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk), .n_rst(n_rst), .start(start),
      .center_row(center_row), .center_col(center_col),
      .busy(busy), .err(err), .mem_addr(mem_addr), .mem_rd(mem_rd),
      .mem_data(mem_data), .window(window), .valid(valid)
   );

   // Memory: content is addr ^ salt, returned RD_LAT cycles after the strobe; junk otherwise.
   logic [AW-1:0] ret_addr;
   logic          ret_rd;
   logic [DW-1:0] junk;

   generate
      if (RD_LAT == 1) begin : g_l1
         assign ret_addr = mem_addr;
         assign ret_rd   = mem_rd;
      end else begin : g_ln
         logic [AW-1:0] a_d [RD_LAT-1];
         logic          r_d [RD_LAT-1];
         always @(posedge clk) begin
            a_d[0] <= mem_addr;
            r_d[0] <= mem_rd;
            for (int i = 1; i < int'(RD_LAT) - 1; i++) begin
               a_d[i] <= a_d[i-1];
               r_d[i] <= r_d[i-1];
            end
         end
         assign ret_addr = a_d[RD_LAT-2];
         assign ret_rd   = r_d[RD_LAT-2];
      end
   endgenerate

   always @(posedge clk) junk <= DW'($urandom);
   always_comb mem_data = ret_rd ? (DW'(ret_addr) ^ salt) : junk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int clampi(input int v, input int hi);
      return (v < 0) ? 0 : ((v > hi) ? hi : v);
   endfunction

   function automatic int exp_addr(input int row, input int col, input int t);
      int r, c;
      r = clampi(row + t / K - HALF, IMG_H - 1);
      c = clampi(col + t % K - HALF, IMG_W - 1);
      return r * IMG_W + c;
   endfunction

   function automatic logic [DW-1:0] exp_tap(input int row, input int col, input int t);
      int r, c;
      r = row + t / K - HALF;
      c = col + t % K - HALF;
`ifdef KWIN_ZERO_PAD_EN
      if (r < 0 || r >= int'(IMG_H) || c < 0 || c >= int'(IMG_W)) return '0;
`endif
      return DW'(exp_addr(row, col, t)) ^ salt;
   endfunction

   function automatic logic [DW-1:0] get_tap(input int t);
      return window[t*DW +: DW];
   endfunction

   // Observe one fetch from the cycle after acceptance up to one cycle past valid.
   task automatic watch(input int row, input int col, input bit noisy);
      int cyc  = 0;
      int vcyc = -1;
      int addrs[$];
      while (vcyc < 0 && cyc < KK + int'(RD_LAT) + 20) begin
         @(negedge clk);
         cyc++;
         if (mem_rd) addrs.push_back(int'(mem_addr));
         check_eq("err_while_busy", err, 0);
         if (valid) vcyc = cyc;
         if (noisy) begin
            start      = 1'($urandom_range(0, 1));
            center_row = AW'($urandom_range(0, 300));
            center_col = AW'($urandom_range(0, 300));
         end
      end
      check_eq("valid_latency", 64'(vcyc), 64'(KK + int'(RD_LAT)));
      check_eq("read_count", 64'(addrs.size()), 64'(KK));
      for (int t = 0; t < KK && t < addrs.size(); t++)
         check_eq($sformatf("addr_tap%0d_r%0d_c%0d", t, row, col), 64'(addrs[t]),
                  64'(exp_addr(row, col, t)));
      check_eq("busy_in_valid_cycle", busy, 1);
      for (int t = 0; t < KK; t++)
         check_eq($sformatf("tap%0d_r%0d_c%0d", t, row, col), get_tap(t), exp_tap(row, col, t));
      @(negedge clk);
      check_eq("valid_one_cycle", valid, 0);
      check_eq("busy_after_valid", busy, 0);
   endtask

   // Called at a negedge; presents start for the next edge (E0).
   task automatic fetch(input int row, input int col, input bit noisy, input bit hold);
      start      = 1'b1;
      center_row = AW'(row);
      center_col = AW'(col);
      @(negedge clk);
      check_eq("busy_on_accept", busy, 1);
      if (!hold) start = 1'b0;
      watch(row, col, noisy);
      if (!hold) start = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int row, col;
      n_rst      = 1'b0;
      start      = 1'b0;
      center_row = '0;
      center_col = '0;
      salt       = '0;
      repeat (2) @(negedge clk);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_err", err, 0);
      check_eq("rst_valid", valid, 0);
      check_eq("rst_mem_rd", mem_rd, 0);
      check_eq("rst_mem_addr", mem_addr, 0);
      check_eq("rst_window", 64'(|window), 0);
      n_rst = 1'b1;
      @(negedge clk);

      // Interior, identity memory
      fetch(5, 7, 1'b0, 1'b0);
      check_eq("r5c7_tap0", get_tap(0), 1030);
      check_eq("r5c7_tap8", get_tap(8), 1544);

      // Top-left corner
      fetch(0, 0, 1'b0, 1'b0);
      check_eq("r0c0_tap8", get_tap(8), 257);
`ifdef KWIN_ZERO_PAD_EN
      check_eq("r0c0_tap6", get_tap(6), 0);
      check_eq("r0c0_tap4", get_tap(4), 0);
`else
      check_eq("r0c0_tap6", get_tap(6), 256);
      check_eq("r0c0_tap2", get_tap(2), 1);
`endif

      // Bottom-right corner
      fetch(255, 255, 1'b0, 1'b0);
`ifdef KWIN_ZERO_PAD_EN
      check_eq("r255c255_tap8", get_tap(8), 0);
      check_eq("r255c255_tap4", get_tap(4), 65535);
`else
      check_eq("r255c255_tap8", get_tap(8), 65535);
      check_eq("r255c255_tap0", get_tap(0), 65278);
`endif

      // Out-of-range centres
      for (int k = 0; k < 2; k++) begin
         start      = 1'b1;
         center_row = (k == 0) ? AW'(256) : AW'(3);
         center_col = (k == 0) ? AW'(3) : AW'(IMG_W + 40);
         @(negedge clk);
         start = 1'b0;
         check_eq("oor_err_pulse", err, 1);
         check_eq("oor_busy", busy, 0);
         check_eq("oor_no_rd", mem_rd, 0);
         @(negedge clk);
         check_eq("oor_err_one_cycle", err, 0);
         check_eq("oor_busy_later", busy, 0);
         check_eq("oor_no_rd_later", mem_rd, 0);
      end

      // start held high: one fetch, the next accepted the cycle after valid
      salt = DW'($urandom);
      fetch(100, 200, 1'b0, 1'b1);
      check_eq("hold_idle_no_rd", mem_rd, 0);
      @(negedge clk);
      check_eq("hold_second_accept", busy, 1);
      start = 1'b0;
      watch(100, 200, 1'b0);

      // Reset during ISSUE while tap 4 is on the bus
      start      = 1'b1;
      center_row = AW'(20);
      center_col = AW'(30);
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check_eq("pre_rst_rd", mem_rd, 1);
      check_eq("pre_rst_addr_tap4", mem_addr, 64'(exp_addr(20, 30, 4)));
      n_rst = 1'b0;
      #1;
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_mem_rd", mem_rd, 0);
      check_eq("midrst_mem_addr", mem_addr, 0);
      check_eq("midrst_valid", valid, 0);
      check_eq("midrst_window", 64'(|window), 0);
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      repeat (6) begin
         @(negedge clk);
         check_eq("postrst_idle_valid", valid, 0);
         check_eq("postrst_idle_rd", mem_rd, 0);
      end
      salt = DW'($urandom);
      fetch(21, 31, 1'b0, 1'b0);

      // Randomised fetches with edge-biased centres and start noise while busy
      for (int n = 0; n < 40; n++) begin
         salt = DW'($urandom);
         row = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, IMG_H - 1));
         col = ($urandom_range(0, 2) == 0) ? int'(IMG_W - 1 - $urandom_range(0, 2)) : int'($urandom_range(0, IMG_W - 1));
         fetch(row, col, n[0], 1'b0);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
